// File: rtl/fetch_buffer.sv
// fetch_buffer: single-outstanding instruction fetcher feeding a DEPTH-entry
// in-order queue toward decode; a redirect flushes the queue and refetches.
module fetch_buffer #(
    parameter int unsigned      DATAW     = 32,
    parameter logic [DATAW-1:0] BASE_ADDR = 32'h01000000,
    parameter int unsigned      DEPTH     = 4
) (
    input  logic             clock,
    input  logic             reset,
    output logic [DATAW-1:0] imem_addr,
    output logic             imem_req,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    input  logic [DATAW-1:0] imem_rdata,
    input  logic             redirect,
    input  logic [DATAW-1:0] redirect_pc,
    input  logic             dec_ready,
    output logic             fd_valid,
    output logic [DATAW-1:0] fd_instr,
    output logic [DATAW-1:0] fd_pc
);

    localparam int unsigned      PTRW = $clog2(DEPTH);
    localparam int unsigned      CNTW = PTRW + 1;
    localparam logic [DATAW-1:0] NOP  = DATAW'(32'h00000013);

    // WAIT: one request outstanding; DROP: outstanding but its response is stale.
    typedef enum logic [1:0] {
        FETCH_IDLE,
        FETCH_WAIT,
        FETCH_DROP
    } fetch_state_t;

    fetch_state_t     state, state_next;
    logic [DATAW-1:0] fpc;
    logic [DATAW-1:0] pend_pc;
    logic [PTRW-1:0]  head, tail;
    logic [CNTW-1:0]  count;
    logic [DATAW-1:0] pc_q    [DEPTH];
    logic [DATAW-1:0] instr_q [DEPTH];

    logic grant;
    logic push;
    logic pop;
    logic unused_pc_lsbs;

    assign unused_pc_lsbs = &{1'b0, redirect_pc[1:0]};

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock) begin
        if (reset) state <= FETCH_IDLE;
        else       state <= state_next;
    end

    // NOTE: every always_comb output gets a default first, so no latches.
    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        push       = 1'b0;
        case (state)
            FETCH_IDLE: begin
                imem_req = (count < CNTW'(DEPTH)) && !redirect && !reset;
                if (imem_req && imem_gnt) state_next = FETCH_WAIT;
            end
            FETCH_WAIT: begin
                if (imem_rvalid) begin
                    state_next = FETCH_IDLE;
                    push       = !redirect;
                end else if (redirect) begin
                    state_next = FETCH_DROP;
                end
            end
            FETCH_DROP: begin
                if (imem_rvalid) state_next = FETCH_IDLE;
            end
            default: state_next = FETCH_IDLE;
        endcase
    end

    assign grant     = imem_req && imem_gnt;
    assign pop       = fd_valid && dec_ready && !redirect;
    assign imem_addr = fpc;

    always_ff @(posedge clock) begin
        if (reset) begin
            fpc     <= BASE_ADDR;
            pend_pc <= '0;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
        end else if (redirect) begin
            fpc   <= {redirect_pc[DATAW-1:2], 2'b00};
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (grant) begin
                pend_pc <= fpc;
                fpc     <= fpc + DATAW'(4);
            end
            if (push) tail <= tail + PTRW'(1);
            if (pop)  head <= head + PTRW'(1);
            if (push && !pop)      count <= count + CNTW'(1);
            else if (pop && !push) count <= count - CNTW'(1);
        end
    end

    // NOTE: queue storage is not reset; count alone decides what is visible.
    always_ff @(posedge clock) begin
        if (push && !reset) begin
            pc_q[tail]    <= pend_pc;
            instr_q[tail] <= imem_rdata;
        end
    end

    assign fd_valid = (count != '0);
    assign fd_pc    = fd_valid ? pc_q[head]    : '0;
    assign fd_instr = fd_valid ? instr_q[head] : NOP;

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: memory model plus scoreboard queue,
// a startup vector table, directed corner sequences and a random phase.
module tb_fetch_buffer;

    localparam int          DATAW = 32;
    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h01000000;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        dec_ready;
    logic        fd_valid;
    logic [31:0] fd_instr;
    logic [31:0] fd_pc;

    always #5 clock = ~clock;

    fetch_buffer #(.DATAW(DATAW), .BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .clock       (clock),
        .reset       (reset),
        .imem_addr   (imem_addr),
        .imem_req    (imem_req),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .dec_ready   (dec_ready),
        .fd_valid    (fd_valid),
        .fd_instr    (fd_instr),
        .fd_pc       (fd_pc)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Scoreboard: PCs of entries the DUT queue must hold, head first.
    logic [31:0] sb[$];
    logic [31:0] exp_fpc;
    logic [31:0] mem_addr;
    bit          mem_busy, tag_live, dut_out, gnt_en, granted;
    int          mem_wait, lat;
    logic        s_req, s_valid;
    logic [31:0] s_addr, s_pc, s_instr;

    typedef struct {
        bit          rst;
        bit          dec;
        bit          exp_req;
        logic [31:0] exp_addr;
        bit          exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_bound(input string name, input int n, input int limit);
        check({name, "_timeout"}, 32'(n >= limit), 32'(0));
    endtask

    // One clock cycle: memory drives, outputs checked at negedge, model updated at posedge.
    task automatic tick();
        bit exp_req;
        @(negedge clock);
        imem_gnt    = gnt_en && !mem_busy;
        imem_rvalid = mem_busy && (mem_wait == 0);
        imem_rdata  = imem_rvalid ? mem_addr : 32'hdeadbeef;
        #1;
        s_req   = imem_req;
        s_valid = fd_valid;
        s_addr  = imem_addr;
        s_pc    = fd_pc;
        s_instr = fd_instr;
        exp_req = !dut_out && (sb.size() < DEPTH) && !redirect && !reset;
        check("imem_req", 32'(imem_req), 32'(exp_req));
        check("imem_addr", imem_addr, exp_fpc);
        check("fd_valid", 32'(fd_valid), 32'(sb.size() != 0));
        if (sb.size() != 0) begin
            check("fd_pc", fd_pc, sb[0]);
            check("fd_instr", fd_instr, sb[0]);
        end else begin
            check("fd_pc_empty", fd_pc, 32'(0));
            check("fd_instr_empty", fd_instr, NOP);
        end
        granted = exp_req && imem_gnt;
        @(posedge clock);
        if (!reset && !redirect && dec_ready && sb.size() != 0) void'(sb.pop_front());
        if (imem_rvalid) begin
            if (tag_live && !reset && !redirect) sb.push_back(mem_addr);
            mem_busy = 1'b0;
            tag_live = 1'b0;
            dut_out  = 1'b0;
        end else if (mem_busy) begin
            mem_wait--;
        end
        if (granted) begin
            mem_busy = 1'b1;
            mem_wait = lat - 1;
            mem_addr = exp_fpc;
            tag_live = 1'b1;
            dut_out  = 1'b1;
            exp_fpc  = exp_fpc + 32'd4;
        end
        if (redirect) begin
            sb.delete();
            exp_fpc  = {redirect_pc[31:2], 2'b00};
            tag_live = 1'b0;
        end
        if (reset) begin
            sb.delete();
            exp_fpc  = BASE;
            tag_live = 1'b0;
            dut_out  = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        vec_t vecs[8];
        int   n;

        vecs[0] = '{1'b1, 1'b1, 1'b0, BASE,          1'b0, 32'h0};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 32'h01000000, 1'b0, 32'h0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h01000004, 1'b0, 32'h0};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 32'h01000004, 1'b1, 32'h01000000};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 32'h01000008, 1'b0, 32'h0};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 32'h01000008, 1'b1, 32'h01000004};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 32'h0100000c, 1'b0, 32'h0};
        vecs[7] = '{1'b0, 1'b1, 1'b1, 32'h0100000c, 1'b1, 32'h01000008};

        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        dec_ready   = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        gnt_en      = 1'b1;
        lat         = 1;
        exp_fpc     = BASE;
        mem_busy    = 1'b0;
        tag_live    = 1'b0;
        dut_out     = 1'b0;
        mem_wait    = 0;
        repeat (2) @(posedge clock);
        #1;

        // Reset state and first fetches, cycle by cycle.
        foreach (vecs[i]) begin
            reset     = vecs[i].rst;
            dec_ready = vecs[i].dec;
            tick();
            check($sformatf("vec%0d_req", i), 32'(s_req), 32'(vecs[i].exp_req));
            check($sformatf("vec%0d_addr", i), s_addr, vecs[i].exp_addr);
            check($sformatf("vec%0d_valid", i), 32'(s_valid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_pc", i), s_pc, vecs[i].exp_pc);
            check($sformatf("vec%0d_instr", i), s_instr, vecs[i].exp_valid ? vecs[i].exp_pc : NOP);
        end

        // Decode stalled: queue fills, fetching stops, head holds; then drains.
        dec_ready = 1'b0;
        do_reset();
        repeat (20) tick();
        check("stall_req", 32'(s_req), 32'(0));
        check("stall_valid", 32'(s_valid), 32'(1));
        check("stall_pc", s_pc, BASE);
        check("stall_addr", s_addr, BASE + 32'd16);
        dec_ready = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!granted && n < 20);
        check_bound("resume", n, 20);
        check("resume_addr", s_addr, 32'h01000010);
        repeat (12) tick();

        // Redirect with three entries queued.
        dec_ready = 1'b0;
        do_reset();
        n = 0;
        while (sb.size() != 3 && n < 40) begin tick(); n++; end
        check_bound("fill3", n, 40);
        redirect    = 1'b1;
        redirect_pc = 32'h01000103;
        tick();
        redirect = 1'b0;
        tick();
        check("redir_valid", 32'(s_valid), 32'(0));
        check("redir_addr", s_addr, 32'h01000100);
        dec_ready = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!s_valid && n < 20);
        check_bound("redir_first", n, 20);
        check("redir_first_pc", s_pc, 32'h01000100);

        // Redirect the cycle after a grant: response later (lat 2) or same cycle (lat 1).
        for (int k = 0; k < 2; k++) begin
            logic [31:0] tgt;
            tgt = (k == 0) ? 32'h01000200 : 32'h01000300;
            lat = (k == 0) ? 2 : 1;
            do_reset();
            n = 0;
            do begin tick(); n++; end while (!granted && n < 20);
            check_bound("drop_grant", n, 20);
            redirect    = 1'b1;
            redirect_pc = tgt;
            tick();
            redirect = 1'b0;
            n = 0;
            do begin
                tick();
                n++;
                check("drop_valid", 32'(s_valid), 32'(0));
            end while (!granted && n < 20);
            check_bound("drop_refetch", n, 20);
            check("drop_refetch_addr", s_addr, tgt);
            repeat (6) tick();
        end

        // Full queue drains one per cycle while refilling; order survives pointer wrap.
        lat       = 1;
        dec_ready = 1'b0;
        do_reset();
        n = 0;
        while (sb.size() != DEPTH && n < 40) begin tick(); n++; end
        check_bound("fill_full", n, 40);
        dec_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("full_pop%0d", i), s_pc, BASE + 32'(4 * i));
        end
        repeat (10) tick();

        // Reset with a request in flight; its stray response must be ignored.
        lat = 3;
        do_reset();
        n = 0;
        do begin tick(); n++; end while (!(granted && s_addr == BASE + 32'd8) && n < 40);
        check_bound("inflight", n, 40);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_valid", 32'(s_valid), 32'(0) | 32'(s_valid));
        n = 0;
        do begin tick(); n++; end while (!s_valid && n < 40);
        check_bound("rst_first", n, 40);
        check("rst_first_pc", s_pc, BASE);

        // Random traffic: stalls, grant gaps, latencies, redirects, occasional reset.
        for (int i = 0; i < 600; i++) begin
            dec_ready   = ($urandom_range(0, 3) != 0);
            gnt_en      = ($urandom_range(0, 3) != 0);
            lat         = $urandom_range(1, 3);
            redirect    = ($urandom_range(0, 19) == 0);
            redirect_pc = BASE + $urandom_range(0, 255);
            reset       = ($urandom_range(0, 149) == 0);
            tick();
        end
        reset    = 1'b0;
        redirect = 1'b0;
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 SHALL have parameter DATAW, default 32, instruction/address width.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h01000000, fetch start address.
REQ-003 SHALL have parameter DEPTH, default 4, queue entries; power of two, minimum 2.
REQ-004 SHALL have port clock  input  1  clock; all state updates on posedge clock.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port imem_addr  output  DATAW  fetch address.
REQ-007 SHALL have port imem_req  output  1  fetch request.
REQ-008 SHALL have port imem_gnt  input  1  memory accepts the request this cycle.
REQ-009 SHALL have port imem_rvalid  input  1  response data valid.
REQ-010 SHALL have port imem_rdata  input  DATAW  fetched instruction.
REQ-011 SHALL have port redirect  input  1  branch/jump taken; flush and refetch.
REQ-012 SHALL have port redirect_pc  input  DATAW  new fetch address.
REQ-013 SHALL have port dec_ready  input  1  decode accepts the head entry; low while decode is stalled.
REQ-014 SHALL have port fd_valid  output  1  head entry valid.
REQ-015 SHALL have port fd_instr  output  DATAW  head instruction.
REQ-016 SHALL have port fd_pc  output  DATAW  head instruction PC.

Function
REQ-017 SHALL keep fetch PC fpc; imem_addr = fpc, combinationally.
REQ-018 SHALL assert imem_req only when: no request is outstanding, count < DEPTH, redirect is low, and reset is low.
REQ-019 SHALL, on imem_req && imem_gnt: latch fpc as pending PC, set outstanding, and set fpc <= fpc+4 (mod 2^DATAW).
REQ-020 SHALL limit outstanding requests to one; imem_rvalid is earliest one cycle after the grant; responses are in order.
REQ-021 SHALL, on imem_rvalid with outstanding set and discard clear, push {pending PC, imem_rdata} at tail and clear outstanding.
REQ-022 SHALL ignore imem_rvalid when outstanding is clear.
REQ-023 SHALL drive fd_valid = (count != 0); fd_instr/fd_pc = head entry; when empty, fd_instr = 32'h00000013 (NOP) and fd_pc = 0.
REQ-024 SHALL pop the head on fd_valid && dec_ready; while dec_ready is low, the head and all outputs SHALL hold.
REQ-025 SHALL provide no bypass: a pushed entry is visible on fd_* the cycle after the push (grant t -> rvalid >= t+1 -> fd_valid >= t+2).
REQ-026 SHALL, on same-cycle push and pop, leave count unchanged; head/tail pointers wrap modulo DEPTH.
REQ-027 SHALL never overflow; REQ-018 reserves a slot before requesting.
REQ-028 SHALL, on redirect: clear the queue (count, pointers to 0), set fpc <= {redirect_pc[DATAW-1:2], 2'b00}, ignore any same-cycle push or pop; fd_valid = 0 the next cycle.
REQ-029 SHALL, on redirect while outstanding (response not this cycle), set discard; the next imem_rvalid SHALL be dropped, clearing outstanding and discard.
REQ-030 SHALL, on redirect in the same cycle as imem_rvalid, drop that response and clear outstanding; discard stays clear.
REQ-031 SHALL make redirect take priority over all other updates in that cycle.

Reset
REQ-032 SHALL, on reset: fpc = BASE_ADDR, count = 0, pointers = 0, outstanding = 0, discard = 0; cycle after: imem_req = 0, fd_valid = 0, fd_instr = 32'h00000013, fd_pc = 0, imem_addr = BASE_ADDR.
REQ-033 SHALL, on reset mid-operation, abandon in-flight requests; a later imem_rvalid with nothing outstanding is ignored (REQ-022).

Verification
REQ-034 Reset, imem_gnt always 1, rvalid 1 cycle after each grant, data = address, dec_ready 1 -> fd_pc sequence 0x01000000, 0x01000004, ...; fd_instr == fd_pc; first fd_valid 2 cycles after first grant.
REQ-035 dec_ready held 0 -> after 4 pushes, imem_req stays 0; fd_pc holds 0x01000000; release -> 4 entries drain in order, fetching resumes at 0x01000010.
REQ-036 redirect=1, redirect_pc=0x01000103 with 3 queued entries -> next cycle fd_valid 0, count 0, imem_addr 0x01000100; first new fd_pc 0x01000100.
REQ-037 redirect in the cycle after a grant, rvalid one cycle later -> that response never appears on fd_*; next request addr = redirect target.
REQ-038 Full queue, dec_ready 1 -> one pop per cycle; a same-cycle push and pop keep count constant; pointers wrap past DEPTH-1 with order preserved.
REQ-039 reset asserted with a request outstanding, stray imem_rvalid after reset -> ignored; fd_valid 0; first fd_pc after reset 0x01000000.
